// File: rtl/pulse_counter_pkg.sv
// Shared types and defaults for the press-driven down counter.
package pulse_counter_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_INIT = 4'hF;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_EXPIRED = 1'b1
  } state_e;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge qualifier for the synchronized press input.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_accept
);

  logic r_in_d;

  // Reset to 1 so a press already held when reset drops is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_d <= 1'b1;
    end else begin
      r_in_d <= i_in;
    end
  end

  assign o_accept = i_in & ~r_in_d;

endmodule

// File: rtl/pulse_down_counter.sv
// Loadable down counter driven by qualified press edges, with terminal-count flag.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_RUN     | presses decrement the count
// ST_EXPIRED | count reached 0 with WRAP=0; presses ignored until reload
module pulse_down_counter
  import pulse_counter_pkg::*;
#(
  parameter int unsigned          WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0]     INIT  = DEF_INIT,
  parameter bit                   WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero,
  output logic             o_tc,
  output logic             o_expired
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam state_e           RST_STATE = ((INIT == '0) && !WRAP) ? ST_EXPIRED : ST_RUN;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic             w_accept;
  logic             r_zero;
  logic             r_tc;
  logic             r_expired;

  edge_rise u_edge_rise (
    .clk      (clk),
    .rst      (rst),
    .i_in     (i_in),
    .o_accept (w_accept)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_load) begin
          w_count_nxt = i_load_val;
          if ((i_load_val == '0) && !WRAP) begin
            w_state_nxt = ST_EXPIRED;
          end
        end else if (w_accept) begin
          if (r_count == ONE) begin
            w_count_nxt = '0;
            w_tc_nxt    = 1'b1;
            if (!WRAP) begin
              w_state_nxt = ST_EXPIRED;
            end
          end else begin
            // 0 - 1 wraps to all-ones; only reachable with WRAP=1
            w_count_nxt = r_count - ONE;
          end
        end
      end
      ST_EXPIRED: begin
        if (i_load && (i_load_val != '0)) begin
          w_state_nxt = ST_RUN;
          w_count_nxt = i_load_val;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RST_STATE;
      r_count   <= INIT;
      r_zero    <= (INIT == '0);
      r_tc      <= 1'b0;
      r_expired <= (RST_STATE == ST_EXPIRED);
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_zero    <= (w_count_nxt == '0);
      r_tc      <= w_tc_nxt;
      r_expired <= (w_state_nxt == ST_EXPIRED);
    end
  end

  assign o_count   = r_count;
  assign o_zero    = r_zero;
  assign o_tc      = r_tc;
  assign o_expired = r_expired;

endmodule
